// File: rtl/zap_mac_iter_pkg.sv
// Shared definitions for the iterative multiply-accumulate unit: multiply
// opcodes, FSM state encoding and opcode decode helpers.
package zap_mac_iter_pkg;

  localparam int OP_UMLALL = 16;
  localparam int OP_UMLALH = 17;
  localparam int OP_SMLALL = 18;
  localparam int OP_SMLALH = 19;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mac_state_e;

  function automatic logic is_mul_op(input int op);
    return (op == OP_UMLALL) || (op == OP_UMLALH) ||
           (op == OP_SMLALL) || (op == OP_SMLALH);
  endfunction

  function automatic logic is_signed_mul(input int op);
    return (op == OP_SMLALL) || (op == OP_SMLALH);
  endfunction

  function automatic logic is_high_mul(input int op);
    return (op == OP_UMLALH) || (op == OP_SMLALH);
  endfunction

endpackage

// File: rtl/zap_mac_iter_pp_step.sv
// One partial-product step: acc + ext(rm) * chunk(rs) << (cnt*CHUNK_W),
// modulo 2^64. Only the top chunk of a signed multiply is sign-extended.
module zap_mac_iter_pp_step #(
  parameter int CHUNK_W = 8,
  parameter int CNT_W   = 2
) (
  input  logic [63:0]        acc_i,
  input  logic [32:0]        rm_ext_i,
  input  logic [CHUNK_W-1:0] chunk_i,
  input  logic [CNT_W-1:0]   cnt_i,
  input  logic               signed_i,
  output logic [63:0]        acc_o
);

  localparam int ITERS = 32 / CHUNK_W;

  logic               chunk_neg_s;
  logic signed [63:0] rm64_s;
  logic signed [63:0] ch64_s;
  logic signed [63:0] prod_s;

  assign chunk_neg_s = signed_i && (int'(cnt_i) == ITERS - 1) && chunk_i[CHUNK_W-1];
  assign rm64_s      = {{31{rm_ext_i[32]}}, rm_ext_i};
  assign ch64_s      = {{(64-CHUNK_W){chunk_neg_s}}, chunk_i};
  assign prod_s      = rm64_s * ch64_s;
  assign acc_o       = acc_i + (prod_s << (int'(cnt_i) * CHUNK_W));

endmodule

// File: rtl/zap_mac_iter.sv
// Iterative 32x32+64 multiply-accumulate unit. Consumes CHUNK_W bits of rs
// per cycle and returns the low or high word of rm*rs + {rh,rn}.
// Optional result cache enabled by defining ZAP_MAC_CACHE_EN: an identical
// multiply issued right after (e.g. the H half after the L half) returns
// from the cache without stalling.
module zap_mac_iter
  import zap_mac_iter_pkg::*;
#(
  parameter int ALU_OPS = 32,
  parameter int CHUNK_W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_clear_from_writeback,
  input  logic                       i_data_stall,
  input  logic                       i_clear_from_alu,
  input  logic [$clog2(ALU_OPS)-1:0] i_alu_operation_ff,
  input  logic                       i_cc_satisfied,
  input  logic [31:0]                i_rm,
  input  logic [31:0]                i_rs,
  input  logic [31:0]                i_rh,
  input  logic [31:0]                i_rn,
  output logic [31:0]                o_rd,
  output logic                       o_busy
);

  localparam int ITERS = 32 / CHUNK_W;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  mac_state_e         state_q;
  logic [63:0]        acc_q;
  logic [63:0]        acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        rm_q;
  logic [31:0]        rs_q;
  logic               sgn_q;
  logic               hi_q;

  logic               mul_req_s;
  logic               req_sgn_s;
  logic               req_hi_s;
  logic               hit_s;
  logic [31:0]        hit_rd_s;
  logic [CHUNK_W-1:0] chunk_s;
  logic [32:0]        rm_ext_s;
  logic               busy_s;
  logic [31:0]        rd_s;
  logic               clear_s;

  assign mul_req_s = i_cc_satisfied && is_mul_op(int'(i_alu_operation_ff));
  assign req_sgn_s = is_signed_mul(int'(i_alu_operation_ff));
  assign req_hi_s  = is_high_mul(int'(i_alu_operation_ff));
  assign clear_s   = i_clear_from_writeback || (!i_data_stall && i_clear_from_alu);

  assign rm_ext_s = {sgn_q & rm_q[31], rm_q};
  assign chunk_s  = CHUNK_W'(rs_q >> (int'(cnt_q) * CHUNK_W));

  zap_mac_iter_pp_step #(
    .CHUNK_W (CHUNK_W),
    .CNT_W   (CNT_W)
  ) u_pp_step (
    .acc_i    (acc_q),
    .rm_ext_i (rm_ext_s),
    .chunk_i  (chunk_s),
    .cnt_i    (cnt_q),
    .signed_i (sgn_q),
    .acc_o    (acc_d)
  );

`ifdef ZAP_MAC_CACHE_EN
  logic        c_valid_q;
  logic        c_sgn_q;
  logic [31:0] c_rm_q;
  logic [31:0] c_rs_q;
  logic [31:0] c_rh_q;
  logic [31:0] c_rn_q;
  logic [63:0] c_acc_q;
  logic [31:0] rh_q;
  logic [31:0] rn_q;

  assign hit_s = (state_q == ST_IDLE) && mul_req_s && c_valid_q &&
                 (c_sgn_q == req_sgn_s) && (c_rm_q == i_rm) && (c_rs_q == i_rs) &&
                 (c_rh_q == i_rh) && (c_rn_q == i_rn);
  assign hit_rd_s = req_hi_s ? c_acc_q[63:32] : c_acc_q[31:0];
`else
  assign hit_s    = 1'b0;
  assign hit_rd_s = 32'd0;
`endif

  // Stall request and result selection from the current state.
  always_comb begin
    busy_s = 1'b0;
    rd_s   = 32'd0;
    case (state_q)
      ST_IDLE: begin
        busy_s = mul_req_s & ~hit_s;
        rd_s   = hit_s ? hit_rd_s : 32'd0;
      end
      ST_BUSY: begin
        busy_s = 1'b1;
      end
      ST_DONE: begin
        rd_s = hi_q ? acc_q[63:32] : acc_q[31:0];
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Outputs are forced quiet while reset is asserted, even if a request is present.
  assign o_busy = i_reset_n & busy_s;
  assign o_rd   = i_reset_n ? rd_s : 32'd0;

  // FSM, accumulator, latched operands and (optionally) the result cache.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      acc_q   <= 64'd0;
      cnt_q   <= '0;
      rm_q    <= 32'd0;
      rs_q    <= 32'd0;
      sgn_q   <= 1'b0;
      hi_q    <= 1'b0;
`ifdef ZAP_MAC_CACHE_EN
      c_valid_q <= 1'b0;
      c_sgn_q   <= 1'b0;
      c_rm_q    <= 32'd0;
      c_rs_q    <= 32'd0;
      c_rh_q    <= 32'd0;
      c_rn_q    <= 32'd0;
      c_acc_q   <= 64'd0;
      rh_q      <= 32'd0;
      rn_q      <= 32'd0;
`endif
    end else if (clear_s) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
`ifdef ZAP_MAC_CACHE_EN
      c_valid_q <= 1'b0;
`endif
    end else if (!i_data_stall) begin
      case (state_q)
        ST_IDLE: begin
          if (mul_req_s && !hit_s) begin
            acc_q   <= {i_rh, i_rn};
            rm_q    <= i_rm;
            rs_q    <= i_rs;
            sgn_q   <= req_sgn_s;
            hi_q    <= req_hi_s;
            cnt_q   <= '0;
            state_q <= ST_BUSY;
`ifdef ZAP_MAC_CACHE_EN
            rh_q    <= i_rh;
            rn_q    <= i_rn;
`endif
          end
        end
        ST_BUSY: begin
          acc_q <= acc_d;
          if (int'(cnt_q) == ITERS - 1) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
`ifdef ZAP_MAC_CACHE_EN
          c_valid_q <= 1'b1;
          c_sgn_q   <= sgn_q;
          c_rm_q    <= rm_q;
          c_rs_q    <= rs_q;
          c_rh_q    <= rh_q;
          c_rn_q    <= rn_q;
          c_acc_q   <= acc_q;
`endif
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zap_mac_iter.sv
// Self-checking bench for zap_mac_iter: directed cases, stall/clear/reset
// scenarios and randomized multiplies against a plain-arithmetic model.
module tb_zap_mac_iter;
  import zap_mac_iter_pkg::*;

  localparam int CHUNK_W = 8;
  localparam int ITERS   = 32 / CHUNK_W;
  localparam int FULL_N  = ITERS + 1;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_clear_from_writeback;
  logic        i_data_stall;
  logic        i_clear_from_alu;
  logic [4:0]  i_alu_operation_ff;
  logic        i_cc_satisfied;
  logic [31:0] i_rm, i_rs, i_rh, i_rn;
  logic [31:0] o_rd;
  logic        o_busy;

  int vectors;
  int miscompares;

  // model cache state (only consulted when the cache is built in)
  bit          mdl_valid;
  bit          mdl_sgn;
  logic [31:0] mdl_rm, mdl_rs, mdl_rh, mdl_rn;

  zap_mac_iter #(.ALU_OPS(32), .CHUNK_W(CHUNK_W)) dut (
    .i_clk                  (i_clk),
    .i_reset_n              (i_reset_n),
    .i_clear_from_writeback (i_clear_from_writeback),
    .i_data_stall           (i_data_stall),
    .i_clear_from_alu       (i_clear_from_alu),
    .i_alu_operation_ff     (i_alu_operation_ff),
    .i_cc_satisfied         (i_cc_satisfied),
    .i_rm                   (i_rm),
    .i_rs                   (i_rs),
    .i_rh                   (i_rh),
    .i_rn                   (i_rn),
    .o_rd                   (o_rd),
    .o_busy                 (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [63:0] ref_mac(bit sgn, logic [31:0] rm, logic [31:0] rs,
                                          logic [31:0] rh, logic [31:0] rn);
    longint a, b;
    if (sgn) begin
      a = longint'($signed(rm));
      b = longint'($signed(rs));
    end else begin
      a = longint'({32'd0, rm});
      b = longint'({32'd0, rs});
    end
    return 64'(a * b) + {rh, rn};
  endfunction

  function automatic logic [31:0] ref_rd(logic [4:0] op, logic [31:0] rm, logic [31:0] rs,
                                         logic [31:0] rh, logic [31:0] rn);
    logic [63:0] r;
    r = ref_mac(op == 5'd18 || op == 5'd19, rm, rs, rh, rn);
    return (op == 5'd17 || op == 5'd19) ? r[63:32] : r[31:0];
  endfunction

  function automatic bit mdl_hit(logic [4:0] op, logic [31:0] rm, logic [31:0] rs,
                                 logic [31:0] rh, logic [31:0] rn);
`ifdef ZAP_MAC_CACHE_EN
    return mdl_valid && (mdl_sgn == (op == 5'd18 || op == 5'd19)) &&
           mdl_rm == rm && mdl_rs == rs && mdl_rh == rh && mdl_rn == rn;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int mdl_busy(logic [4:0] op, logic [31:0] rm, logic [31:0] rs,
                                  logic [31:0] rh, logic [31:0] rn);
    return mdl_hit(op, rm, rs, rh, rn) ? 0 : FULL_N;
  endfunction

  task automatic mdl_store(logic [4:0] op, logic [31:0] rm, logic [31:0] rs,
                           logic [31:0] rh, logic [31:0] rn);
    mdl_valid = 1'b1;
    mdl_sgn   = (op == 5'd18 || op == 5'd19);
    mdl_rm = rm; mdl_rs = rs; mdl_rh = rh; mdl_rn = rn;
  endtask

  // Issue one instruction and count the cycles o_busy is high; rd is o_rd
  // in the first non-busy cycle (DONE, cache hit or non-multiply).
  task automatic do_op(input logic [4:0] op, input logic cc, input logic [31:0] rm,
                       input logic [31:0] rs, input logic [31:0] rh, input logic [31:0] rn,
                       output int n, output logic [31:0] rd);
    @(negedge i_clk);
    i_alu_operation_ff = op; i_cc_satisfied = cc;
    i_rm = rm; i_rs = rs; i_rh = rh; i_rn = rn;
    #1;
    n = 0;
    while (o_busy === 1'b1 && n < 200) begin
      @(negedge i_clk); #1;
      n++;
    end
    rd = o_rd;
    i_cc_satisfied = 1'b0;
    if (cc && n == FULL_N) mdl_store(op, rm, rs, rh, rn);
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_clear_from_writeback = 1'b0; i_data_stall = 1'b0; i_clear_from_alu = 1'b0;
    i_alu_operation_ff = 5'd16; i_cc_satisfied = 1'b1;
    i_rm = 32'd7; i_rs = 32'd9; i_rh = 32'd0; i_rn = 32'd0;
    mdl_valid = 1'b0;
    #1;
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy got %b want 0", o_busy);
    end
    vectors++;
    if (o_rd !== 32'd0) begin
      miscompares++; $display("FAIL reset_rd got %h want 00000000", o_rd);
    end
    @(negedge i_clk); i_cc_satisfied = 1'b0;
    @(negedge i_clk); i_reset_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [4:0]  ops [7];
    logic [31:0] rms [7], rss [7], rhs [7], rns [7], exp_rd [7];
    logic        ccs [7];
    int          exp_n;
    int          n;
    logic [31:0] rd;
    ops = '{5'd16, 5'd17, 5'd19, 5'd18, 5'd16, 5'd18, 5'd16};
    ccs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    rms = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd2, 32'hFFFFFFFE, 32'h80000000};
    rss = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd3, 32'd3, 32'd3, 32'h80000000};
    rhs = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0};
    rns = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0};
    exp_rd = '{32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA,
               32'h00000005, 32'h00000000, 32'h00000000};
    for (int i = 0; i < 7; i++) begin
      exp_n = ccs[i] ? mdl_busy(ops[i], rms[i], rss[i], rhs[i], rns[i]) : 0;
      do_op(ops[i], ccs[i], rms[i], rss[i], rhs[i], rns[i], n, rd);
      vectors++;
      if (n !== exp_n) begin
        miscompares++; $display("FAIL directed%0d_busy got %0d want %0d", i, n, exp_n);
      end
      vectors++;
      if (rd !== exp_rd[i]) begin
        miscompares++; $display("FAIL directed%0d_rd got %h want %h", i, rd, exp_rd[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] rm, rs, rh, rn, rd;
    int n;
    rm = $urandom; rs = $urandom; rh = $urandom; rn = $urandom;
    @(negedge i_clk);
    i_alu_operation_ff = 5'd19; i_cc_satisfied = 1'b1;
    i_rm = rm; i_rs = rs; i_rh = rh; i_rn = rn;
    #1;
    n = 0;
    while (o_busy === 1'b1 && n < 200) begin
      if (n == 2) i_data_stall = 1'b1;
      if (n == 5) i_data_stall = 1'b0;
      @(negedge i_clk); #1;
      n++;
    end
    rd = o_rd;
    i_cc_satisfied = 1'b0; i_data_stall = 1'b0;
    mdl_store(5'd19, rm, rs, rh, rn);
    vectors++;
    if (n !== FULL_N + 3) begin
      miscompares++; $display("FAIL stall_busy got %0d want %0d", n, FULL_N + 3);
    end
    vectors++;
    if (rd !== ref_rd(5'd19, rm, rs, rh, rn)) begin
      miscompares++; $display("FAIL stall_rd got %h want %h", rd, ref_rd(5'd19, rm, rs, rh, rn));
    end
  endtask

  task automatic test_clear();
    logic [31:0] rm, rs, rd;
    int n;
    rm = $urandom; rs = $urandom;
    do_op(5'd16, 1'b1, rm, rs, 32'd0, 32'd0, n, rd);
    // start a different multiply and abort it in busy cycle 2
    @(negedge i_clk);
    i_alu_operation_ff = 5'd16; i_cc_satisfied = 1'b1;
    i_rm = rm ^ 32'h1; i_rs = rs; i_rh = 32'd0; i_rn = 32'd0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_clear_from_alu = 1'b1; i_cc_satisfied = 1'b0;
    @(negedge i_clk);
    i_clear_from_alu = 1'b0;
    mdl_valid = 1'b0;
    #1;
    vectors++;
    if (o_busy !== 1'b0 || o_rd !== 32'd0) begin
      miscompares++; $display("FAIL clear_alu_idle got busy=%b rd=%h want busy=0 rd=00000000", o_busy, o_rd);
    end
    do_op(5'd16, 1'b1, rm, rs, 32'd0, 32'd0, n, rd);
    vectors++;
    if (n !== FULL_N) begin
      miscompares++; $display("FAIL clear_recompute_busy got %0d want %0d", n, FULL_N);
    end
    vectors++;
    if (rd !== ref_rd(5'd16, rm, rs, 32'd0, 32'd0)) begin
      miscompares++; $display("FAIL clear_recompute_rd got %h want %h", rd, ref_rd(5'd16, rm, rs, 32'd0, 32'd0));
    end
    // writeback clear must win over a simultaneous data stall
    @(negedge i_clk);
    i_alu_operation_ff = 5'd18; i_cc_satisfied = 1'b1;
    i_rm = $urandom; i_rs = $urandom;
    @(negedge i_clk);
    i_clear_from_writeback = 1'b1; i_data_stall = 1'b1; i_cc_satisfied = 1'b0;
    @(negedge i_clk);
    i_clear_from_writeback = 1'b0; i_data_stall = 1'b0;
    mdl_valid = 1'b0;
    #1;
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++; $display("FAIL clear_wb_over_stall got busy=%b want 0", o_busy);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rm, rs, rh, rn, rd;
    int n;
    @(negedge i_clk);
    i_alu_operation_ff = 5'd17; i_cc_satisfied = 1'b1;
    i_rm = $urandom; i_rs = $urandom;
    @(negedge i_clk);
    @(negedge i_clk);
    #2;
    i_reset_n = 1'b0;
    #1;
    vectors++;
    if (o_busy !== 1'b0 || o_rd !== 32'd0) begin
      miscompares++; $display("FAIL async_reset got busy=%b rd=%h want busy=0 rd=00000000", o_busy, o_rd);
    end
    i_cc_satisfied = 1'b0;
    mdl_valid = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    rm = $urandom; rs = $urandom; rh = $urandom; rn = $urandom;
    do_op(5'd16, 1'b1, rm, rs, rh, rn, n, rd);
    vectors++;
    if (n !== FULL_N || rd !== ref_rd(5'd16, rm, rs, rh, rn)) begin
      miscompares++; $display("FAIL post_reset_L got n=%0d rd=%h want n=%0d rd=%h",
                              n, rd, FULL_N, ref_rd(5'd16, rm, rs, rh, rn));
    end
`ifdef ZAP_MAC_CACHE_EN
    do_op(5'd17, 1'b1, rm, rs, rh, rn, n, rd);
    vectors++;
    if (n !== 0 || rd !== ref_rd(5'd17, rm, rs, rh, rn)) begin
      miscompares++; $display("FAIL cache_hit_H got n=%0d rd=%h want n=0 rd=%h",
                              n, rd, ref_rd(5'd17, rm, rs, rh, rn));
    end
`else
    do_op(5'd17, 1'b1, rm, rs, rh, rn, n, rd);
    vectors++;
    if (n !== FULL_N || rd !== ref_rd(5'd17, rm, rs, rh, rn)) begin
      miscompares++; $display("FAIL nocache_H got n=%0d rd=%h want n=%0d rd=%h",
                              n, rd, FULL_N, ref_rd(5'd17, rm, rs, rh, rn));
    end
`endif
  endtask

  task automatic test_random();
    logic [4:0]  op;
    logic        cc;
    logic [31:0] rm, rs, rh, rn, rd, exp_rd;
    int n, exp_n;
    rm = 32'd0; rs = 32'd0; rh = 32'd0; rn = 32'd0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(1, 0) == 0 || i == 0) begin
        rm = $urandom; rs = $urandom; rh = $urandom; rn = $urandom;
        case ($urandom_range(3, 0))
          0: rs = 32'h80000000 | rs;
          1: rm = 32'hFFFFFFFF;
          default: ;
        endcase
      end
      op = 5'($urandom_range(19, 16));
      if ($urandom_range(7, 0) == 0) op = 5'($urandom_range(15, 0));
      cc = ($urandom_range(9, 0) != 0);
      if (cc && op >= 5'd16) begin
        exp_n  = mdl_busy(op, rm, rs, rh, rn);
        exp_rd = ref_rd(op, rm, rs, rh, rn);
      end else begin
        exp_n  = 0;
        exp_rd = 32'd0;
      end
      do_op(op, cc, rm, rs, rh, rn, n, rd);
      vectors++;
      if (n !== exp_n) begin
        miscompares++; $display("FAIL random%0d_busy op=%0d got %0d want %0d", i, op, n, exp_n);
      end
      vectors++;
      if (rd !== exp_rd) begin
        miscompares++; $display("FAIL random%0d_rd op=%0d got %h want %h", i, op, rd, exp_rd);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_stall();
    test_clear();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
